// File: rtl/soc_system_key_ctrl_if.sv
// -----------------------------------------------------------------------------
// soc_system_key_ctrl_if
// Avalon-MM slave bus bundle for the debounced key controller.
//   address    : word address of the register to access
//   chipselect : slave select
//   write_n    : active-low write strobe, meaningful only with chipselect
//   writedata  : write data
//   readdata   : registered read data returned by the slave
// Modports: master (bridge side) and slave (key controller side).
// -----------------------------------------------------------------------------
interface soc_system_key_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_key_ctrl.sv
// -----------------------------------------------------------------------------
// soc_system_key_ctrl
// Debounced push-button controller with press capture and interrupt, mapped
// as an Avalon-MM slave behind the lightweight HPS-to-FPGA bridge.
//
// Ports:
//   clk      : system clock (single domain)
//   reset_n  : asynchronous active-low reset
//   avs      : Avalon-MM slave bus (address, chipselect, write_n, writedata,
//              readdata)
//   in_port  : raw key pins, asynchronous, 0 = pressed
//   irq      : level interrupt, active high
//
// Register map (word address):
//   0 DATA    RO    debounced key levels
//   1 IRQMASK RW    per-key interrupt enable
//   2 EDGECAP R/W1C captured events
//   3 PERIOD  RW    debounce period in clk cycles (0 behaves as 1)
//
// Build option KEY_BOTHEDGE_EN: when defined, releases also set EDGECAP and
// address 3 bits [31:28] report RELSTATE (last event type, 1 = release) for
// keys 0..3. When undefined, only presses are captured and those bits read 0.
// -----------------------------------------------------------------------------
module soc_system_key_ctrl #(
  parameter int NKEYS       = 4,
  parameter int CNT_W       = 20,
  parameter int DEB_DEFAULT = 500000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  soc_system_key_ctrl_if.slave avs,
  input  logic [NKEYS-1:0]     in_port,
  output logic                 irq
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic wr_mask;
  logic wr_edge;
  logic wr_period;

  assign wr_en     = avs.chipselect & ~avs.write_n;
  assign wr_mask   = wr_en && (avs.address == 2'd1);
  assign wr_edge   = wr_en && (avs.address == 2'd2);
  assign wr_period = wr_en && (avs.address == 2'd3);

  // Upper writedata bits beyond the register widths are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs.writedata;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] data_q, data_d;
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [NKEYS-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  // Per-key "DATA takes the synced level this cycle" strobes.
  logic [NKEYS-1:0] key_upd;
  logic [NKEYS-1:0] edge_set;

  // Terminal count is PERIOD-1, with a PERIOD of 0 treated as 1.
  logic [CNT_W-1:0] period_m1;
  logic             period_one;

  assign period_m1  = (period_q == '0) ? '0 : (period_q - CNT_W'(1));
  assign period_one = (period_m1 == '0);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer, reset to released level
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce FSM
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      deb_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             upd;
      logic             diff;

      assign diff = (sync2_q[gi] != data_q[gi]);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upd     = 1'b0;
        if (wr_period) begin
          // A new period restarts every key; DATA is left untouched.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            ST_STABLE: begin
              cnt_d = '0;
              if (diff) begin
                if (period_one) begin
                  // One differing sample is already the full period.
                  upd = 1'b1;
                end else begin
                  state_d = ST_COUNT;
                  cnt_d   = CNT_W'(1);
                end
              end
            end
            ST_COUNT: begin
              if (!diff) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
              end else if (cnt_q >= period_m1) begin
                // Compare before increment so the counter can never wrap.
                upd     = 1'b1;
                state_d = ST_STABLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            default: begin
              state_d = ST_STABLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign key_upd[gi] = upd;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event capture. A press is an update while DATA is still 1.
  // ---------------------------------------------------------------------------
`ifdef KEY_BOTHEDGE_EN
  assign edge_set = key_upd;

  logic [3:0]  relstate_q, relstate_d;
  logic [31:0] upd_pad;
  logic [31:0] data_pad;

  assign upd_pad  = 32'(key_upd);
  assign data_pad = 32'(data_q);

  // New level after an update is ~data_q, which is 1 exactly for a release.
  always_comb begin
    relstate_d = relstate_q;
    for (int i = 0; i < 4; i++) begin
      if (upd_pad[i]) relstate_d[i] = ~data_pad[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) relstate_q <= '0;
    else          relstate_q <= relstate_d;
  end
`else
  assign edge_set = key_upd & data_q;
`endif

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d   = data_q ^ key_upd;
    mask_d   = wr_mask ? avs.writedata[NKEYS-1:0] : mask_q;
    period_d = wr_period ? avs.writedata[CNT_W-1:0] : period_q;
    // Clear first, then set, so a same-cycle set wins.
    edge_d   = (edge_q & ~(wr_edge ? avs.writedata[NKEYS-1:0] : '0)) | edge_set;
    irq_d    = |(edge_q & mask_q);
  end

  // Read mux is sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (avs.address)
      2'd0: readdata_d = 32'(data_q);
      2'd1: readdata_d = 32'(mask_q);
      2'd2: readdata_d = 32'(edge_q);
      2'd3: begin
`ifdef KEY_BOTHEDGE_EN
        readdata_d = 32'(period_q) | {relstate_q, 28'd0};
`else
        readdata_d = 32'(period_q);
`endif
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '1;
      mask_q     <= '0;
      edge_q     <= '0;
      period_q   <= CNT_W'(DEB_DEFAULT);
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      period_q   <= period_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soc_system_key_ctrl
// Directed bench for soc_system_key_ctrl: reset state, debounce timing, glitch
// rejection, interrupt masking/clearing, set-wins-over-clear, period rewrite,
// period zero and simultaneous presses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_soc_system_key_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  soc_system_key_ctrl_if bus ();

  soc_system_key_ctrl #(
    .NKEYS      (4),
    .CNT_W      (20),
    .DEB_DEFAULT(500000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single bus write; returns on the falling edge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    $display("WR addr=%0d data=0x%08h", a, d);
  endtask

  // Single read with one-cycle latency.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(posedge clk);
    #1 d = bus.readdata;
    $display("RD addr=%0d data=0x%08h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata got=0x%08h exp=0x00000000", bus.readdata);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'h0000000F) begin
      n_fail++; $display("FAIL reset_data got=0x%08h exp=0x0000000f", v);
    end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL reset_mask got=0x%08h exp=0x00000000", v);
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL reset_edgecap got=0x%08h exp=0x00000000", v);
    end
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'h0007A120) begin
      n_fail++; $display("FAIL reset_period got=0x%08h exp=0x0007a120", v);
    end
  endtask

  task automatic test_debounce_latency();
    logic [31:0] v;
    wr(2'd3, 32'd4);
    @(negedge clk);
    bus.address = 2'd0;
    in_port[0]  = 1'b0;
    // DATA updates on the 6th edge; readdata shows it on the 7th.
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'hF) begin
      n_fail++; $display("FAIL press_early got=0x%08h exp=0x0000000f", bus.readdata);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'hE) begin
      n_fail++; $display("FAIL press_data got=0x%08h exp=0x0000000e", bus.readdata);
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL press_edgecap got=0x%08h exp=0x00000001", v);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL press_irq_masked got=%b exp=0", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (10) @(posedge clk);
    wr(2'd2, 32'h1);
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    repeat (10) @(posedge clk);
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'hF) begin
      n_fail++; $display("FAIL glitch_data got=0x%08h exp=0x0000000f", v);
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL glitch_edgecap got=0x%08h exp=0x00000000", v);
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(2'd1, 32'h2);
    @(negedge clk);
    bus.address = 2'd0;
    in_port[1]  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_early got=%b exp=0", irq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_assert got=%b exp=1", irq);
    end
    wr(2'd2, 32'h1);
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_wrong_clear got=%b exp=1", irq);
    end
    wr(2'd2, 32'h2);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_clear_lat got=%b exp=1", irq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_deassert got=%b exp=0", irq);
    end
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL irq_edgecap_cleared got=0x%08h exp=0x00000000", v);
    end
    wr(2'd1, 32'h0);
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (10) @(posedge clk);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL release_no_edge got=0x%08h exp=0x00000000", v);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    @(negedge clk);
    bus.address = 2'd0;
    in_port[2]  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.address    = 2'd2;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h4;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    $display("WR addr=2 data=0x00000004 (coincident with press)");
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h4) begin
      n_fail++; $display("FAIL set_wins got=0x%08h exp=0x00000004", v);
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'hB) begin
      n_fail++; $display("FAIL set_wins_data got=0x%08h exp=0x0000000b", v);
    end
    wr(2'd2, 32'h4);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL w1c_clear got=0x%08h exp=0x00000000", v);
    end
  endtask

  task automatic test_period_rewrite();
    @(negedge clk);
    in_port[2] = 1'b1;
    repeat (10) @(posedge clk);
    wr(2'd3, 32'd100);
    @(negedge clk);
    bus.address = 2'd0;
    in_port[3]  = 1'b0;
    // Counter reaches 50 after 52 edges (two synchronizer edges first).
    repeat (52) @(posedge clk);
    @(negedge clk);
    bus.address    = 2'd3;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'd10;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    $display("WR addr=3 data=0x0000000a (mid-count)");
    // Write edge W is behind us; DATA falls at W+10, visible at W+11.
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'hF) begin
      n_fail++; $display("FAIL rewrite_early got=0x%08h exp=0x0000000f", bus.readdata);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'h7) begin
      n_fail++; $display("FAIL rewrite_data got=0x%08h exp=0x00000007", bus.readdata);
    end
  endtask

  task automatic test_period_zero();
    logic [31:0] v;
    wr(2'd3, 32'd0);
    rd(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL period_zero_rd got=0x%08h exp=0x00000000", v);
    end
    @(negedge clk);
    bus.address = 2'd0;
    in_port[3]  = 1'b1;
    // Period 0 acts as 1: DATA updates on edge 3, visible on edge 4.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'h7) begin
      n_fail++; $display("FAIL period_zero_early got=0x%08h exp=0x00000007", bus.readdata);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdata !== 32'hF) begin
      n_fail++; $display("FAIL period_zero_data got=0x%08h exp=0x0000000f", bus.readdata);
    end
  endtask

  task automatic test_multi_key();
    logic [31:0] v;
    wr(2'd2, 32'hF);
    wr(2'd3, 32'd4);
    @(negedge clk);
    in_port[1:0] = 2'b00;
    repeat (10) @(posedge clk);
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'h3) begin
      n_fail++; $display("FAIL multi_edgecap got=0x%08h exp=0x00000003", v);
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'hC) begin
      n_fail++; $display("FAIL multi_data got=0x%08h exp=0x0000000c", v);
    end
    wr(2'd0, 32'h0);
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'hC) begin
      n_fail++; $display("FAIL data_readonly got=0x%08h exp=0x0000000c", v);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_irq();
    test_set_wins();
    test_period_rewrite();
    test_period_zero();
    test_multi_key();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_key_ctrl.md
Name: soc_system_key_ctrl

Overview:
Avalon-MM slave that debounces the 4 push-button inputs, captures press events and raises an interrupt to the HPS. Sits between the board KEY pins and the lightweight HPS-to-FPGA bridge, replacing the plain input PIO. It adds per-key debounce sequencing, edge capture with write-1-to-clear, and a programmable debounce period.

Parameters:
NKEYS, 4, number of key inputs (1..32)
CNT_W, 20, debounce counter width in bits
DEB_DEFAULT, 500000, reset value of the debounce period register in clk cycles (10 ms at 50 MHz); must fit in CNT_W

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous active-low reset
address  input  2  register select, word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; valid only with chipselect
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  NKEYS  raw key pins, asynchronous; 0 = pressed, 1 = released
irq  output  1  level interrupt to HPS, active high

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (reset_n). All flops clear on reset_n low regardless of clk.
- Register map:
  - 0 DATA (RO): debounced levels, bits [NKEYS-1:0]
  - 1 IRQMASK (RW): per-key interrupt enable
  - 2 EDGECAP (R/W1C): press events
  - 3 PERIOD (RW): debounce period, bits [CNT_W-1:0]
  - Unused bits read 0.
- Reset values:
  - readdata = 0, irq = 0
  - DATA = all 1s (released)
  - IRQMASK = 0, EDGECAP = 0
  - PERIOD = DEB_DEFAULT
  - synchronizer flops = all 1s, counters = 0
- Reads:
  - readdata updates every clk with the mux of address, independent of chipselect.
  - 1-cycle latency: data for the address presented in cycle N is visible in cycle N+1.
- Writes: take effect on the clk edge where chipselect=1 and write_n=0. Writes to DATA are ignored.
- Synchronizer: 2-flop per key; the synced level is used everywhere downstream.
- Debounce FSM, per key, two states:
  - STABLE: synced == DATA bit, counter held at 0.
    - synced != DATA bit -> COUNT, counter = 1.
  - COUNT:
    - synced == DATA bit -> STABLE, counter = 0 (glitch rejected).
    - else, if counter == PERIOD-1 -> DATA bit = synced, state STABLE, counter = 0.
    - else counter += 1.
  - Net effect: DATA follows a change after exactly PERIOD consecutive differing synced samples. Total pin-to-DATA latency = PERIOD + 2 clocks.
  - PERIOD written as 0 behaves as 1.
  - Counter never wraps: the terminal compare precedes increment.
- PERIOD write:
  - All counters clear and all FSMs return to STABLE in the same cycle; DATA keeps its value.
  - Keys still differing restart counting with the new period.
- EDGECAP: bit i sets in the cycle DATA[i] transitions 1->0 (debounced press). Releases do not set it unless the optional feature is enabled.
- EDGECAP write: bits written 1 clear, bits written 0 unchanged.
- Set and clear on the same bit in the same cycle: set wins, bit stays 1.
- irq: registered, irq <= |(EDGECAP & IRQMASK). Asserts 1 clk after the EDGECAP bit sets, or 1 clk after an IRQMASK write enables a pending bit. Deasserts 1 clk after clear or mask.
- Multiple keys changing simultaneously: each key's FSM is independent; several EDGECAP bits may set in one cycle.

Optional Feature:
KEY_BOTHEDGE_EN
- Defined: EDGECAP bit i also sets on a DATA[i] 0->1 transition (release). A 4-bit RO register RELSTATE at address 3 bits [31:28] reports the last event type per key for keys 0..3 (1 = release, 0 = press). RELSTATE bit i updates on each EDGECAP set of key i and clears to 0 on reset.
- Undefined: presses only; bits [31:28] of address 3 read 0.

Test Plan:
1. Reset release with in_port=4'hF -> readdata=0, irq=0. Read address 0 -> 0x0000000F. Read address 3 -> 500000 (0x7A120).
2. PERIOD=4, in_port[0] low held -> DATA bit 0 falls exactly 6 clks after pin change. EDGECAP reads 0x1. irq stays 0 because IRQMASK=0.
3. PERIOD=4, in_port[1] low for 3 clks then high -> DATA stays 0xF and EDGECAP stays 0 (glitch rejected).
4. IRQMASK=0x2, then key 1 press -> irq=1 one clk after EDGECAP[1] sets. Write 0x2 to address 2 -> irq=0 one clk later. Write 0x1 instead -> irq stays 1.
5. Write EDGECAP=0x4 in the same cycle key 2's debounced press lands -> EDGECAP[2] reads 1 (set wins).
6. PERIOD=100, key 3 mid-count at 50, write PERIOD=10 -> DATA bit 3 falls 10 clks after the write, not 50.
